// File: rtl/gato_pkg.sv
// Shared constants and helpers for the tic-tac-toe button front-end.
// Button indices double as arbitration priority (lowest index wins).
package gato_pkg;

  localparam int NUM_BOTONES = 5;

  localparam int BTN_ELIGE  = 0;
  localparam int BTN_ARRIBA = 1;
  localparam int BTN_ABAJO  = 2;
  localparam int BTN_IZQ    = 3;
  localparam int BTN_DER    = 4;

  localparam int DEBOUNCE_DEF     = 500000;
  localparam int REPEAT_DELAY_DEF = 25000000;
  localparam int REPEAT_RATE_DEF  = 10000000;

  // Isolates the lowest set bit, i.e. the highest-priority event.
  function automatic logic [NUM_BOTONES-1:0] prioriza(
    input logic [NUM_BOTONES-1:0] ev
  );
    return ev & (~ev + NUM_BOTONES'(1));
  endfunction

endpackage

// File: rtl/entrada_botones_antirrebote.sv
// One button channel: 2-FF sync, debouncer, press detect, repeat timer.
// The repeat timer exists only when GATO_AUTOREPEAT_EN is defined.
module antirrebote
  import gato_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic evento
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          est;
  logic          est_d;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          disparo;

  assign rise = est & ~est_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      est    <= 1'b0;
      est_d  <= 1'b0;
      cnt    <= '0;
      evento <= 1'b0;
    end else begin
      s1     <= boton;
      s2     <= s1;
      est_d  <= est;
      evento <= rise | disparo;
      if (s2 == est) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        est <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef GATO_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int TMAX =
      (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW = $clog2(TMAX + 1);

    logic [TW-1:0] tmr;
    logic          rep;

    // tmr counts cycles since the last emitted event of this hold.
    assign disparo = est & ~rise &
      (tmr == (rep ? TW'(REPEAT_RATE - 1) : TW'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk) begin
      if (reset || !est || rise) begin
        tmr <= '0;
        rep <= 1'b0;
      end else if (disparo) begin
        tmr <= '0;
        rep <= 1'b1;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end else begin : g_norep
    assign disparo = 1'b0;
  end
`else
  assign disparo = 1'b0;
`endif

endmodule

// File: rtl/entrada_botones.sv
// Button front-end: five debounced channels, priority arbiter, enable gate.
// Optional autorepeat on directional buttons via GATO_AUTOREPEAT_EN.
module entrada_botones
  import gato_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic habilita,
  input  logic boton_arriba_in,
  input  logic boton_abajo_in,
  input  logic boton_izq_in,
  input  logic boton_der_in,
  input  logic boton_elige_in,
  output logic boton_arriba_reg,
  output logic boton_abajo_reg,
  output logic boton_izq_reg,
  output logic boton_der_reg,
  output logic boton_elige_reg
);

  logic [NUM_BOTONES-1:0] raw;
  logic [NUM_BOTONES-1:0] ev;
  logic [NUM_BOTONES-1:0] strobe;

  assign raw[BTN_ELIGE]  = boton_elige_in;
  assign raw[BTN_ARRIBA] = boton_arriba_in;
  assign raw[BTN_ABAJO]  = boton_abajo_in;
  assign raw[BTN_IZQ]    = boton_izq_in;
  assign raw[BTN_DER]    = boton_der_in;

  for (genvar i = 0; i < NUM_BOTONES; i++) begin : g_ch
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (i != BTN_ELIGE)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .boton (raw[i]),
      .evento(ev[i])
    );
  end

  // Losing events are dropped; nothing is queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe <= '0;
    end else begin
      strobe <= habilita ? prioriza(ev) : '0;
    end
  end

  assign boton_elige_reg  = strobe[BTN_ELIGE];
  assign boton_arriba_reg = strobe[BTN_ARRIBA];
  assign boton_abajo_reg  = strobe[BTN_ABAJO];
  assign boton_izq_reg    = strobe[BTN_IZQ];
  assign boton_der_reg    = strobe[BTN_DER];

endmodule
